lsu_queue_fifo: RTL and testbench

//  Parametrised in-order queue between LSU issue and the memory port; successor to the fixed 17-entry LSU FIFO.

---
 rtl/lsu_queue_fifo_pkg.sv | 21 ++
 rtl/lsu_fifo_fwd_match.sv | 40 ++++
 rtl/lsu_queue_fifo.sv | 127 ++++++++++++
 tb/tb_lsu_queue_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_queue_fifo_pkg.sv
// Shared defaults and helpers for the LSU queue FIFO.
// Default geometry lives here; the LSU_FIFO_FWD_EN macro enables forwarding in the top.
package lsu_queue_fifo_pkg;

    localparam int DEF_FIFOWIDE = 23;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_ADDRWIDE = 12;
    localparam int DEF_AFULLLVL = 12;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e decodeOp(input logic wrAcc, input logic rdAcc);
        return fifo_op_e'({wrAcc, rdAcc});
    endfunction

endpackage

// File: rtl/lsu_fifo_fwd_match.sv
// Store-to-load forwarding search over the occupied FIFO entries.
// Scans oldest to youngest so the last match found is the youngest one.
module lsu_fifo_fwd_match #(
    parameter int FIFOWIDE = 23,
    parameter int DEPTH    = 16,
    parameter int ADDRWIDE = 12
) (
    input  logic [FIFOWIDE-1:0]        i_mem [DEPTH],
    input  logic [$clog2(DEPTH):0]     i_rptr,
    input  logic [$clog2(DEPTH):0]     i_wptr,
    input  logic [ADDRWIDE-1:0]        i_fwdAddr,
    output logic                       o_fwdHit,
    output logic [FIFOWIDE-1:0]        o_fwdData
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    w_occ;
    logic [DEPTH-1:0] w_match;
    logic [AW-1:0]    w_idx;

    always_comb begin
        w_occ     = i_wptr - i_rptr;
        w_match   = '0;
        w_idx     = '0;
        o_fwdHit  = 1'b0;
        o_fwdData = '0;
        // Offset k counts from the head; only offsets below the occupancy are live entries.
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_rptr[AW-1:0] + AW'(k);
            w_match[k] = (PW'(k) < w_occ) && (i_mem[w_idx][ADDRWIDE-1:0] == i_fwdAddr);
            if (w_match[k]) begin
                o_fwdHit  = 1'b1;
                o_fwdData = i_mem[w_idx];
            end
        end
    end

endmodule

// File: rtl/lsu_queue_fifo.sv
// Parametrised in-order LSU queue with registered read, head peek and error pulses.
// Define LSU_FIFO_FWD_EN to add the store-to-load forwarding ports and search.
module lsu_queue_fifo
    import lsu_queue_fifo_pkg::*;
#(
    parameter int FIFOWIDE = DEF_FIFOWIDE,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDRWIDE = DEF_ADDRWIDE,
    parameter int AFULLLVL = DEF_AFULLLVL
) (
    input  logic                       Clk,
    input  logic                       Rest,
    input  logic                       Wable,
    input  logic [FIFOWIDE-1:0]        Din,
    input  logic                       Rable,
    output logic [FIFOWIDE-1:0]        Dout,
    output logic                       DoutValid,
    output logic [FIFOWIDE-1:0]        FifoPreOut,
    input  logic                       FifoClean,
    output logic                       FifoFull,
    output logic                       FifoEmpty,
    output logic                       AlmostFull,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       OvfErr,
    output logic                       UdfErr
`ifdef LSU_FIFO_FWD_EN
    ,
    input  logic [ADDRWIDE-1:0]        FwdAddr,
    output logic                       FwdHit,
    output logic [FIFOWIDE-1:0]        FwdData
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (ADDRWIDE > FIFOWIDE) begin : g_badAddrWide
        $error("lsu_queue_fifo: ADDRWIDE must not exceed FIFOWIDE");
    end

    logic [FIFOWIDE-1:0] r_mem [DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [FIFOWIDE-1:0] r_dout;
    logic                r_doutValid;
    logic                r_ovf;
    logic                r_udf;

    logic                w_full;
    logic                w_empty;
    logic                w_wrAcc;
    logic                w_rdAcc;
    fifo_op_e            w_op;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_wrAcc = Wable && !w_full;
    assign w_rdAcc = Rable && !w_empty;
    assign w_op    = decodeOp(w_wrAcc, w_rdAcc);

    always_ff @(posedge Clk) begin
        if (Rest && !FifoClean && w_wrAcc) begin
            r_mem[r_wptr[AW-1:0]] <= Din;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rest) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else if (FifoClean) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            case (w_op)
                OP_WR:   r_wptr <= r_wptr + 1'b1;
                OP_RD:   r_rptr <= r_rptr + 1'b1;
                OP_RW: begin
                    r_wptr <= r_wptr + 1'b1;
                    r_rptr <= r_rptr + 1'b1;
                end
                default: ;
            endcase
            if (w_rdAcc) begin
                r_dout <= r_mem[r_rptr[AW-1:0]];
            end
            r_doutValid <= w_rdAcc;
            r_ovf       <= Wable && w_full;
            r_udf       <= Rable && w_empty;
        end
    end

    assign Dout       = r_dout;
    assign DoutValid  = r_doutValid;
    assign FifoPreOut = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign FifoFull   = w_full;
    assign FifoEmpty  = w_empty;
    assign Count      = r_wptr - r_rptr;
    assign AlmostFull = (Count >= PW'(AFULLLVL));
    assign OvfErr     = r_ovf;
    assign UdfErr     = r_udf;

`ifdef LSU_FIFO_FWD_EN
    lsu_fifo_fwd_match #(
        .FIFOWIDE (FIFOWIDE),
        .DEPTH    (DEPTH),
        .ADDRWIDE (ADDRWIDE)
    ) u_fwdMatch (
        .i_mem     (r_mem),
        .i_rptr    (r_rptr),
        .i_wptr    (r_wptr),
        .i_fwdAddr (FwdAddr),
        .o_fwdHit  (FwdHit),
        .o_fwdData (FwdData)
    );
`endif

endmodule

// File: tb/tb_lsu_queue_fifo.sv
// Directed self-checking bench for lsu_queue_fifo (default 23x16 geometry).
// Forwarding steps are included when LSU_FIFO_FWD_EN is defined.
module tb_lsu_queue_fifo;

    localparam int FW = 23;
    localparam int DP = 16;
    localparam int AD = 12;

    logic          Clk = 1'b0;
    logic          Rest;
    logic          Wable;
    logic [FW-1:0] Din;
    logic          Rable;
    logic [FW-1:0] Dout;
    logic          DoutValid;
    logic [FW-1:0] FifoPreOut;
    logic          FifoClean;
    logic          FifoFull;
    logic          FifoEmpty;
    logic          AlmostFull;
    logic [4:0]    Count;
    logic          OvfErr;
    logic          UdfErr;
`ifdef LSU_FIFO_FWD_EN
    logic [AD-1:0] FwdAddr;
    logic          FwdHit;
    logic [FW-1:0] FwdData;
`endif

    int total = 0;
    int bad   = 0;
    logic [FW-1:0] model [$];
    logic [FW-1:0] expVal;
    int            wn;

    always #5 Clk = ~Clk;

    lsu_queue_fifo #(
        .FIFOWIDE (FW),
        .DEPTH    (DP),
        .ADDRWIDE (AD),
        .AFULLLVL (12)
    ) dut (
        .Clk        (Clk),
        .Rest       (Rest),
        .Wable      (Wable),
        .Din        (Din),
        .Rable      (Rable),
        .Dout       (Dout),
        .DoutValid  (DoutValid),
        .FifoPreOut (FifoPreOut),
        .FifoClean  (FifoClean),
        .FifoFull   (FifoFull),
        .FifoEmpty  (FifoEmpty),
        .AlmostFull (AlmostFull),
        .Count      (Count),
        .OvfErr     (OvfErr),
        .UdfErr     (UdfErr)
`ifdef LSU_FIFO_FWD_EN
        ,
        .FwdAddr    (FwdAddr),
        .FwdHit     (FwdHit),
        .FwdData    (FwdData)
`endif
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Rest = 1'b0; Wable = 1'b0; Rable = 1'b0; FifoClean = 1'b0; Din = '0;
`ifdef LSU_FIFO_FWD_EN
        FwdAddr = '0;
`endif
        // T1: reset then fill to full, one overflow attempt
        step(); step();
        chk("rst_count", 32'(Count), 0);
        chk("rst_empty", 32'(FifoEmpty), 1);
        chk("rst_dvalid", 32'(DoutValid), 0);
        chk("rst_dout", 32'(Dout), 0);
        chk("rst_preout", 32'(FifoPreOut), 0);
        chk("rst_ovf", 32'(OvfErr), 0);
        Rest = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            Wable = 1'b1; Din = FW'(i);
            step();
            chk("fill_count", 32'(Count), 32'(i));
            chk("fill_afull", 32'(AlmostFull), (i >= 12) ? 1 : 0);
        end
        chk("fill_full", 32'(FifoFull), 1);
        chk("fill_preout", 32'(FifoPreOut), 32'h1);
        Din = FW'('h11);
        step();
        chk("ovf_pulse", 32'(OvfErr), 1);
        chk("ovf_count", 32'(Count), 16);
        Wable = 1'b0;
        step();
        chk("ovf_clear", 32'(OvfErr), 0);

        // T2: drain with one underflow attempt
        Rable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("drain_dout", 32'(Dout), 32'(i));
            chk("drain_dvalid", 32'(DoutValid), 1);
            chk("drain_count", 32'(Count), 32'(16 - i));
        end
        chk("drain_empty", 32'(FifoEmpty), 1);
        step();
        chk("udf_pulse", 32'(UdfErr), 1);
        chk("udf_dout_hold", 32'(Dout), 32'h10);
        chk("udf_dvalid", 32'(DoutValid), 0);
        Rable = 1'b0;
        step();
        chk("udf_clear", 32'(UdfErr), 0);

        // T3: preload 5, then 40 concurrent read+write cycles across the wrap
        wn = 0;
        for (int i = 0; i < 5; i++) begin
            Wable = 1'b1; Din = FW'(32'h100 + wn);
            model.push_back(Din);
            wn++;
            step();
        end
        chk("pre_count", 32'(Count), 5);
        for (int i = 0; i < 40; i++) begin
            Rable = 1'b1; Wable = 1'b1; Din = FW'(32'h100 + wn);
            chk("rw_preout", 32'(FifoPreOut), 32'(model[0]));
            model.push_back(Din);
            wn++;
            expVal = model.pop_front();
            step();
            chk("rw_dout", 32'(Dout), 32'(expVal));
            chk("rw_count", 32'(Count), 5);
        end
        Rable = 1'b0; Wable = 1'b0;
        step();
        chk("rw_dvalid_idle", 32'(DoutValid), 0);

        // T4: grow to 7 then flush with read and write requested
        for (int i = 0; i < 2; i++) begin
            Wable = 1'b1; Din = FW'(32'h200 + i);
            step();
        end
        chk("pre_flush_count", 32'(Count), 7);
        Wable = 1'b1; Rable = 1'b1; FifoClean = 1'b1;
        step();
        chk("flush_count", 32'(Count), 0);
        chk("flush_empty", 32'(FifoEmpty), 1);
        chk("flush_dout", 32'(Dout), 0);
        chk("flush_dvalid", 32'(DoutValid), 0);
        chk("flush_ovf", 32'(OvfErr), 0);
        chk("flush_udf", 32'(UdfErr), 0);
        FifoClean = 1'b0; Rable = 1'b0; Wable = 1'b1; Din = FW'(32'hABC);
        chk("wr_not_peeked", 32'(FifoPreOut), 0);
        step();
        chk("post_flush_preout", 32'(FifoPreOut), 32'hABC);
        chk("post_flush_count", 32'(Count), 1);
        Wable = 1'b0;

`ifdef LSU_FIFO_FWD_EN
        // T5: forwarding picks the youngest matching address
        FifoClean = 1'b1;
        step();
        FifoClean = 1'b0;
        FwdAddr = 12'h040;
        Wable = 1'b1; Din = {11'h0A, 12'h040};
        chk("fwd_same_cycle", 32'(FwdHit), 0);
        step();
        Din = {11'h0B, 12'h080};
        step();
        Din = {11'h0C, 12'h040};
        step();
        Wable = 1'b0;
        chk("fwd_hit", 32'(FwdHit), 1);
        chk("fwd_youngest", 32'(FwdData), 32'({11'h0C, 12'h040}));
        FwdAddr = 12'h080;
        #1;
        chk("fwd_other", 32'(FwdData), 32'({11'h0B, 12'h080}));
        FwdAddr = 12'h123;
        #1;
        chk("fwd_miss_hit", 32'(FwdHit), 0);
        chk("fwd_miss_data", 32'(FwdData), 0);
        FwdAddr = 12'h040;
        Rable = 1'b1;
        step(); step(); step();
        Rable = 1'b0;
        chk("fwd_after_read", 32'(FwdHit), 0);
`endif

        // T6: reset in the middle of a read stream
        FifoClean = 1'b1;
        step();
        FifoClean = 1'b0;
        for (int i = 0; i < 9; i++) begin
            Wable = 1'b1; Din = FW'(32'h300 + i);
            step();
        end
        Wable = 1'b0;
        chk("pre_rst_count", 32'(Count), 9);
        Rable = 1'b1; Rest = 1'b0;
        step();
        chk("midrst_count", 32'(Count), 0);
        chk("midrst_dvalid", 32'(DoutValid), 0);
        chk("midrst_preout", 32'(FifoPreOut), 0);
        chk("midrst_empty", 32'(FifoEmpty), 1);
        Rest = 1'b1; Rable = 1'b0;
        step();
        chk("midrst_stays_empty", 32'(FifoPreOut), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
